// File: rtl/cci_test_csr_pkg.sv
// Shared types and address constants for the test CSR manager and its read FIFO.
package cci_test_csr_pkg;

    localparam int NUM_TEST_CSRS    = 8;
    localparam int NUM_COUNTER_BITS = 40;
    localparam int CSR_IDX_BITS     = 4;
    localparam int TID_BITS         = 9;

    localparam logic [CSR_IDX_BITS-1:0] CSR_IDX_CYCLES = 4'd8;
    localparam logic [CSR_IDX_BITS-1:0] CSR_IDX_CTRL   = 4'd9;
    localparam logic [CSR_IDX_BITS-1:0] CSR_IDX_LIMIT  = 4'd10;

    typedef logic [NUM_COUNTER_BITS-1:0] t_cci_test_counter;

    typedef enum logic [1:0] {
        STATE_IDLE,
        STATE_RUN,
        STATE_DONE
    } t_test_state;

    typedef struct packed {
        logic [CSR_IDX_BITS-1:0] idx;
        logic [TID_BITS-1:0]     tid;
    } t_rd_req;

endpackage

// File: rtl/cci_test_csr_rd_fifo.sv
// Show-ahead FIFO: head is valid whenever empty is low. A push while full is dropped,
// even if a pop happens in the same cycle.
module cci_test_csr_rd_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic
) (
    input  logic clk,
    input  logic reset_n,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     head,
    output logic full,
    output logic empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cci_test_csr_mgr.sv
// Test CSR manager: decodes MMIO writes into test CSR pulses and run control,
// and answers MMIO reads through a request FIFO and a single response register.
module cci_test_csr_mgr
    import cci_test_csr_pkg::*;
#(
    parameter int RD_FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          mmio_wr_valid,
    input  logic [3:0]                    mmio_wr_idx,
    input  logic [63:0]                   mmio_wr_data,
    input  logic                          mmio_rd_valid,
    input  logic [3:0]                    mmio_rd_idx,
    input  logic [8:0]                    mmio_rd_tid,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [8:0]                    rsp_tid,
    output logic [63:0]                   rsp_data,
    output logic                          rd_fifo_full,
    output logic                          rd_overflow,
    input  logic [NUM_TEST_CSRS*64-1:0]   test_rd_csrs,
    output logic [NUM_TEST_CSRS-1:0]      test_wr_en,
    output logic [63:0]                   test_wr_data,
    output logic                          test_running,
    output logic                          test_done,
    output logic [NUM_COUNTER_BITS-1:0]   cycle_count
);

    localparam int SLOT_W = $clog2(NUM_TEST_CSRS);

    t_test_state       state;
    t_test_state       state_next;
    t_cci_test_counter counter;
    t_cci_test_counter counter_next;
    t_cci_test_counter limit;
    logic              ctrl_wr;
    logic              start;
    logic              stop;
    logic              test_wr_hit;
    t_rd_req           rd_req;
    t_rd_req           rd_head;
    logic              rd_empty;
    logic              rsp_load;
    logic [63:0]       rd_data;
    logic [63:0]       csr_slot [NUM_TEST_CSRS];

    for (genvar i = 0; i < NUM_TEST_CSRS; i++) begin : g_slot
        assign csr_slot[i] = test_rd_csrs[64*i +: 64];
    end

    // Stop takes priority over start when both bits are set in one write.
    assign ctrl_wr      = mmio_wr_valid && (mmio_wr_idx == CSR_IDX_CTRL);
    assign start        = ctrl_wr && mmio_wr_data[0] && !mmio_wr_data[1];
    assign stop         = ctrl_wr && mmio_wr_data[1];
    assign test_wr_hit  = mmio_wr_valid && (mmio_wr_idx < 4'(NUM_TEST_CSRS));
    assign test_running = (state == STATE_RUN);
    assign cycle_count  = counter;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= STATE_IDLE;
            counter   <= '0;
            test_done <= 1'b0;
        end else begin
            state     <= state_next;
            counter   <= counter_next;
            test_done <= (state == STATE_RUN) && (state_next == STATE_DONE);
        end
    end

    // A limit already passed (lowered mid-run) ends the run without counting further.
    always_comb begin
        state_next   = state;
        counter_next = counter;
        if (state == STATE_RUN) begin
            if ((limit != '0) && (counter >= limit)) begin
                state_next = STATE_DONE;
            end else begin
                if (counter != '1) begin
                    counter_next = counter + 1'b1;
                end
                if ((limit != '0) && (counter_next == limit)) begin
                    state_next = STATE_DONE;
                end
            end
            if (stop) begin
                state_next   = STATE_DONE;
                counter_next = counter;
            end
        end
        if (start) begin
            state_next   = STATE_RUN;
            counter_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            limit        <= '0;
            test_wr_en   <= '0;
            test_wr_data <= '0;
        end else begin
            test_wr_en <= '0;
            if (test_wr_hit) begin
                test_wr_en[mmio_wr_idx[SLOT_W-1:0]] <= 1'b1;
                test_wr_data                        <= mmio_wr_data;
            end
            if (mmio_wr_valid && (mmio_wr_idx == CSR_IDX_LIMIT)) begin
                limit <= mmio_wr_data[NUM_COUNTER_BITS-1:0];
            end
        end
    end

    assign rd_req.idx = mmio_rd_idx;
    assign rd_req.tid = mmio_rd_tid;

    cci_test_csr_rd_fifo #(
        .DEPTH (RD_FIFO_DEPTH),
        .T     (t_rd_req)
    ) u_rd_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (mmio_rd_valid),
        .push_data (rd_req),
        .pop       (rsp_load),
        .head      (rd_head),
        .full      (rd_fifo_full),
        .empty     (rd_empty)
    );

    // Read data is taken from the live CSR values at the moment the response register loads.
    always_comb begin
        rd_data = '0;
        case (rd_head.idx)
            CSR_IDX_CYCLES: rd_data = 64'(counter);
            CSR_IDX_CTRL:   rd_data = {62'b0, state == STATE_DONE, state == STATE_RUN};
            CSR_IDX_LIMIT:  rd_data = 64'(limit);
            default: begin
                if (rd_head.idx < 4'(NUM_TEST_CSRS)) begin
                    rd_data = csr_slot[rd_head.idx[SLOT_W-1:0]];
                end
            end
        endcase
    end

    assign rsp_load = !rd_empty && (!rsp_valid || rsp_ready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid   <= 1'b0;
            rsp_tid     <= '0;
            rsp_data    <= '0;
            rd_overflow <= 1'b0;
        end else begin
            if (rsp_load) begin
                rsp_valid <= 1'b1;
                rsp_tid   <= rd_head.tid;
                rsp_data  <= rd_data;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            if (mmio_rd_valid && rd_fifo_full) begin
                rd_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cci_test_csr_mgr.sv
// Directed plus randomized bench for cci_test_csr_mgr, checked against a register-level
// model of the CSR map held in plain variables.
module tb_cci_test_csr_mgr;
    import cci_test_csr_pkg::*;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          mmio_wr_valid = 1'b0;
    logic [3:0]    mmio_wr_idx = '0;
    logic [63:0]   mmio_wr_data = '0;
    logic          mmio_rd_valid = 1'b0;
    logic [3:0]    mmio_rd_idx = '0;
    logic [8:0]    mmio_rd_tid = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [8:0]    rsp_tid;
    logic [63:0]   rsp_data;
    logic          rd_fifo_full;
    logic          rd_overflow;
    logic [511:0]  test_rd_csrs;
    logic [7:0]    test_wr_en;
    logic [63:0]   test_wr_data;
    logic          test_running;
    logic          test_done;
    logic [39:0]   cycle_count;

    int            errors = 0;
    int            checks = 0;

    logic [63:0]   model_csr [8];
    logic [39:0]   model_limit = '0;
    logic [39:0]   model_count = '0;
    logic          model_running = 1'b0;
    logic          model_done = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            test_rd_csrs[64*i +: 64] = model_csr[i];
        end
    end

    cci_test_csr_mgr #(.RD_FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .mmio_wr_valid (mmio_wr_valid),
        .mmio_wr_idx   (mmio_wr_idx),
        .mmio_wr_data  (mmio_wr_data),
        .mmio_rd_valid (mmio_rd_valid),
        .mmio_rd_idx   (mmio_rd_idx),
        .mmio_rd_tid   (mmio_rd_tid),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_tid       (rsp_tid),
        .rsp_data      (rsp_data),
        .rd_fifo_full  (rd_fifo_full),
        .rd_overflow   (rd_overflow),
        .test_rd_csrs  (test_rd_csrs),
        .test_wr_en    (test_wr_en),
        .test_wr_data  (test_wr_data),
        .test_running  (test_running),
        .test_done     (test_done),
        .cycle_count   (cycle_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [191:0] observed,
                                input logic [191:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [191:0] all_outputs();
        return {2'b0, rsp_valid, rsp_tid, rsp_data, rd_fifo_full, rd_overflow,
                test_wr_en, test_wr_data, test_running, test_done, cycle_count};
    endfunction

    // Expected read value of any address, from the register-level model.
    function automatic logic [63:0] expect_rd(input logic [3:0] idx);
        if (idx < 4'd8) return model_csr[idx[2:0]];
        case (idx)
            4'd8:    return {24'b0, model_count};
            4'd9:    return {62'b0, model_done, model_running};
            4'd10:   return {24'b0, model_limit};
            default: return 64'b0;
        endcase
    endfunction

    // Presents one write for a single cycle; returns sampled in the following cycle.
    task automatic apply_stimulus(input logic [3:0] idx, input logic [63:0] data);
        mmio_wr_valid = 1'b1;
        mmio_wr_idx   = idx;
        mmio_wr_data  = data;
        tick();
        mmio_wr_valid = 1'b0;
        if (idx == 4'd10) model_limit = data[39:0];
    endtask

    // Single read with rsp_ready high: nothing at N+1, response at N+2.
    task automatic read_check(input string tag, input logic [3:0] idx, input logic [8:0] tid);
        logic [63:0] exp_data;
        mmio_rd_valid = 1'b1;
        mmio_rd_idx   = idx;
        mmio_rd_tid   = tid;
        tick();
        mmio_rd_valid = 1'b0;
        check_output({tag, "_early"}, rsp_valid, 1'b0);
        exp_data = expect_rd(idx);
        tick();
        check_output({tag, "_valid"}, rsp_valid, 1'b1);
        check_output({tag, "_tid"}, rsp_tid, tid);
        check_output({tag, "_data"}, rsp_data, exp_data);
        tick();
    endtask

    initial begin
        logic [3:0]  idx;
        logic [63:0] data;
        logic [8:0]  tid;
        int          run_cycles;
        int          done_pulses;

        for (int i = 0; i < 8; i++) model_csr[i] = 64'h100 + 64'(i);
        rsp_ready = 1'b1;

        #2 reset_n = 1'b0;
        repeat (3) tick();
        check_output("reset_outputs", all_outputs(), '0);
        reset_n = 1'b1;
        tick();
        check_output("post_reset_outputs", all_outputs(), '0);

        apply_stimulus(4'd3, 64'hDEAD_BEEF);
        check_output("wr3_en", test_wr_en, 8'b0000_1000);
        check_output("wr3_data", test_wr_data, 64'hDEAD_BEEF);
        tick();
        check_output("wr3_en_off", test_wr_en, 8'h00);

        mmio_wr_valid = 1'b1; mmio_wr_idx = 4'd0; mmio_wr_data = 64'h11;
        tick();
        check_output("b2b_first", test_wr_en, 8'h01);
        mmio_wr_idx = 4'd7; mmio_wr_data = 64'h77;
        tick();
        mmio_wr_valid = 1'b0;
        check_output("b2b_second", test_wr_en, 8'h80);
        check_output("b2b_second_data", test_wr_data, 64'h77);
        tick();
        check_output("b2b_off", test_wr_en, 8'h00);

        apply_stimulus(4'd12, 64'h5);
        check_output("wr12_no_pulse", test_wr_en, 8'h00);

        model_csr[5] = 64'h1234;
        read_check("rd5", 4'd5, 9'h1A5);
        read_check("rd13", 4'd13, 9'h013);

        // Data must be taken when the response register loads, not at request time.
        mmio_rd_valid = 1'b1; mmio_rd_idx = 4'd2; mmio_rd_tid = 9'h0C2;
        tick();
        mmio_rd_valid = 1'b0;
        model_csr[2] = 64'hCAFE_0002;
        tick();
        check_output("late_sample_data", rsp_data, 64'hCAFE_0002);
        tick();

        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                idx = 4'($urandom_range(0, 15));
                if (idx == 4'd9) idx = 4'd10;
                data = {$urandom, $urandom};
                apply_stimulus(idx, data);
                check_output("rand_wr_en", test_wr_en, (idx < 4'd8) ? (8'd1 << idx[2:0]) : 8'd0);
                if (idx < 4'd8) check_output("rand_wr_data", test_wr_data, data);
                tick();
            end else begin
                model_csr[$urandom_range(0, 7)] = {$urandom, $urandom};
                idx = 4'($urandom_range(0, 15));
                tid = 9'($urandom);
                read_check("rand_rd", idx, tid);
            end
        end

        // Limited run: exactly 100 running cycles, a single done pulse, count held at the limit.
        apply_stimulus(4'd10, 64'd100);
        apply_stimulus(4'd9, 64'h1);
        run_cycles = 0;
        done_pulses = 0;
        for (int c = 0; c < 150; c++) begin
            if (test_running) run_cycles++;
            if (test_done) done_pulses++;
            tick();
        end
        model_running = 1'b0; model_done = 1'b1; model_count = model_limit;
        check_output("limit_run_cycles", 32'(run_cycles), 32'd100);
        check_output("limit_done_pulses", 32'(done_pulses), 32'd1);
        check_output("limit_count_held", cycle_count, 40'd100);
        read_check("limit_ctrl_rd", 4'd9, 9'h009);
        read_check("limit_cycles_rd", 4'd8, 9'h008);
        read_check("limit_limit_rd", 4'd10, 9'h00A);

        // Unlimited run stopped by host after 37 counted cycles.
        apply_stimulus(4'd10, 64'd0);
        apply_stimulus(4'd9, 64'h1);
        check_output("start_count_zero", cycle_count, 40'd0);
        repeat (37) tick();
        apply_stimulus(4'd9, 64'h2);
        check_output("stop_count", cycle_count, 40'd37);
        check_output("stop_not_running", test_running, 1'b0);
        check_output("stop_done_pulse", test_done, 1'b1);
        tick();
        check_output("stop_done_once", test_done, 1'b0);
        model_count = 40'd37;
        read_check("stop_ctrl_rd", 4'd9, 9'h019);

        apply_stimulus(4'd9, 64'h1);
        repeat (5) tick();
        apply_stimulus(4'd9, 64'h3);
        repeat (3) tick();
        check_output("both_bits_count", cycle_count, 40'd5);
        check_output("both_bits_not_running", test_running, 1'b0);
        model_count = 40'd5;
        read_check("both_bits_ctrl_rd", 4'd9, 9'h033);

        // Lowering the limit below the count ends the run on the following cycle.
        apply_stimulus(4'd9, 64'h1);
        repeat (20) tick();
        apply_stimulus(4'd10, 64'd10);
        check_output("lowlim_still_running", test_running, 1'b1);
        tick();
        check_output("lowlim_done", test_done, 1'b1);
        check_output("lowlim_stopped", test_running, 1'b0);
        tick();

        // Backpressure: response register plus four FIFO slots hold five reads; the sixth drops.
        rsp_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            mmio_rd_valid = 1'b1;
            mmio_rd_idx   = 4'(k);
            mmio_rd_tid   = 9'(9'h040 + k);
            tick();
        end
        mmio_rd_valid = 1'b0;
        check_output("ovf_full", rd_fifo_full, 1'b1);
        check_output("ovf_sticky", rd_overflow, 1'b1);
        repeat (2) tick();
        check_output("ovf_hold_valid", rsp_valid, 1'b1);
        check_output("ovf_hold_tid", rsp_tid, 9'h040);
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check_output("drain_valid", rsp_valid, 1'b1);
            check_output("drain_tid", rsp_tid, 9'(9'h040 + k));
            check_output("drain_data", rsp_data, expect_rd(4'(k)));
            tick();
        end
        check_output("drain_empty", rsp_valid, 1'b0);
        check_output("drain_not_full", rd_fifo_full, 1'b0);
        check_output("drain_ovf_kept", rd_overflow, 1'b1);

        // Asynchronous reset in the middle of a run with reads pending.
        apply_stimulus(4'd9, 64'h1);
        rsp_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mmio_rd_valid = 1'b1; mmio_rd_idx = 4'(k); mmio_rd_tid = 9'(9'h070 + k);
            tick();
        end
        mmio_rd_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_output("async_reset_outputs", all_outputs(), '0);
        tick();
        reset_n = 1'b1;
        model_limit = '0; model_count = '0; model_running = 1'b0; model_done = 1'b0;
        rsp_ready = 1'b1;
        repeat (4) tick();
        check_output("after_reset_outputs", all_outputs(), '0);
        apply_stimulus(4'd9, 64'h2);
        check_output("idle_stop_ignored", {test_running, test_done}, 2'b00);
        read_check("after_reset_ctrl_rd", 4'd9, 9'h099);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
